// File: rtl/pps_phase_tracker_if.sv
// Correction bus and measurement status driven by pps_phase_tracker toward the PPS counter.
interface pps_phase_tracker_if;
  logic [7:0]  data_out;
  logic [3:0]  data_wr;
  logic        sload;
  logic [31:0] err_out;
  logic        meas_valid;
  logic        locked;

  modport master (
    output data_out,
    output data_wr,
    output sload,
    output err_out,
    output meas_valid,
    output locked
  );

  modport slave (
    input data_out,
    input data_wr,
    input sload,
    input err_out,
    input meas_valid,
    input locked
  );
endinterface

// File: rtl/pps_phase_tracker.sv
// Measures the phase of an external 1PPS against the local PPS and writes a clamped
// correction to the downstream counter as four bytes followed by a load strobe.
module pps_phase_tracker #(
  parameter logic [31:0] freq     = 32'd4_999_999,
  parameter logic [31:0] max_step = 32'd1000,
  parameter logic [31:0] lock_tol = 32'd2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       in_hz,
  input  logic                       local_pps,
  pps_phase_tracker_if.master        bus
);

  typedef enum logic [3:0] {
    StIdle, StArmed, StCalc, StWr0, StWr1, StWr2, StWr3, StLoad, StHold
  } state_e;

  localparam logic [31:0] HalfFreq = freq >> 1;

  state_e      state_q, state_d;
  logic        hz_meta_q, hz_sync_q, hz_prev_q, loc_prev_q;
  logic        ext_edge, loc_edge;
  logic [31:0] phase_q, phase_d;
  logic [31:0] p_q, p_d;
  logic [31:0] err_q, err_d;
  logic [31:0] corr_q, corr_d;
  logic [2:0]  run_q, run_d;
  logic        meas_valid_q, meas_valid_d;

  logic [31:0] calc_err, clamp_err, abs_err;
  logic        skip_wr, in_tol;
  logic [3:0]  wr;
  logic [7:0]  wr_byte;
  logic        load;
  logic        active;

  assign ext_edge = hz_sync_q & ~hz_prev_q;
  assign loc_edge = local_pps & ~loc_prev_q;
  assign phase_d  = loc_edge ? 32'd0 : ((phase_q >= freq) ? freq : phase_q + 32'd1);

  // Error is the shorter way around the period; negative means the external edge leads.
  always_comb begin
    calc_err = (p_q <= HalfFreq) ? p_q : p_q - (freq + 32'd1);
    if ($signed(calc_err) > $signed(max_step)) begin
      clamp_err = max_step;
    end else if ($signed(calc_err) < -$signed(max_step)) begin
      clamp_err = 32'd0 - max_step;
    end else begin
      clamp_err = calc_err;
    end
    abs_err = calc_err[31] ? (32'd0 - calc_err) : calc_err;
    in_tol  = (abs_err <= lock_tol);
    // Too close to the downstream wrap to land the write safely.
    skip_wr = (({1'b0, p_q} + 33'd7) >= {1'b0, freq});
  end

  always_comb begin
    state_d      = state_q;
    p_d          = p_q;
    err_d        = err_q;
    corr_d       = corr_q;
    run_d        = run_q;
    meas_valid_d = 1'b0;
    unique case (state_q)
      StIdle, StHold: begin
        if (loc_edge) begin
          if (ext_edge) begin
            p_d     = 32'd0;
            state_d = StCalc;
          end else begin
            state_d = StArmed;
          end
        end
      end
      StArmed: begin
        if (ext_edge) begin
          p_d     = phase_d;
          state_d = StCalc;
        end else if (loc_edge) begin
          run_d = 3'd0;
        end
      end
      StCalc: begin
        err_d        = calc_err;
        corr_d       = clamp_err;
        meas_valid_d = 1'b1;
        run_d        = in_tol ? ((run_q == 3'd7) ? 3'd7 : run_q + 3'd1) : 3'd0;
        state_d      = skip_wr ? StHold : StWr0;
      end
      StWr0:   state_d = StWr1;
      StWr1:   state_d = StWr2;
      StWr2:   state_d = StWr3;
      StWr3:   state_d = StLoad;
      StLoad:  state_d = StHold;
      default: state_d = StIdle;
    endcase
    if (!en) begin
      state_d      = StIdle;
      err_d        = err_q;
      corr_d       = corr_q;
      run_d        = 3'd0;
      meas_valid_d = 1'b0;
    end
  end

  always_comb begin
    wr      = 4'b0000;
    wr_byte = 8'h00;
    load    = 1'b0;
    unique case (state_q)
      StWr0:   begin wr = 4'b0001; wr_byte = corr_q[7:0];   end
      StWr1:   begin wr = 4'b0010; wr_byte = corr_q[15:8];  end
      StWr2:   begin wr = 4'b0100; wr_byte = corr_q[23:16]; end
      StWr3:   begin wr = 4'b1000; wr_byte = corr_q[31:24]; end
      StLoad:  load = 1'b1;
      default: ;
    endcase
  end

  assign active         = en & ~reset;
  assign bus.data_wr    = active ? wr : 4'b0000;
  assign bus.data_out   = active ? wr_byte : 8'h00;
  assign bus.sload      = active & load;
  assign bus.err_out    = reset ? 32'd0 : err_q;
  assign bus.meas_valid = active & meas_valid_q;
  assign bus.locked     = active & (run_q >= 3'd4);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      hz_meta_q    <= 1'b0;
      hz_sync_q    <= 1'b0;
      hz_prev_q    <= 1'b0;
      loc_prev_q   <= 1'b0;
      phase_q      <= 32'd0;
      p_q          <= 32'd0;
      err_q        <= 32'd0;
      corr_q       <= 32'd0;
      run_q        <= 3'd0;
      meas_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hz_meta_q    <= in_hz;
      hz_sync_q    <= hz_meta_q;
      hz_prev_q    <= hz_sync_q;
      loc_prev_q   <= local_pps;
      phase_q      <= phase_d;
      p_q          <= p_d;
      err_q        <= err_d;
      corr_q       <= corr_d;
      run_q        <= run_d;
      meas_valid_q <= meas_valid_d;
    end
  end

endmodule

// File: doc/pps_phase_tracker.md
PPS_PHASE_TRACKER -- requirements
Module: pps_phase_tracker

Interface
REQ-001 Parameter freq, 32'd4_999_999: local period minus one, in clk cycles; must match the downstream PPS counter.
REQ-002 Parameter max_step, 32'd1000: magnitude limit for one correction, in cycles.
REQ-003 Parameter lock_tol, 32'd2: maximum |error| counted as in-lock.
REQ-004 clk  in  1  system clock; all logic on posedge clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 en  in  1  tracking enable; low forces IDLE and suppresses all writes.
REQ-007 in_hz  in  1  external 1PPS, asynchronous to clk.
REQ-008 local_pps  in  1  local PPS pulse from the downstream counter, synchronous to clk.
REQ-009 data_out  out  8  correction byte to the downstream counter.
REQ-010 data_wr  out  4  one-hot byte-write strobe; bit k writes correction bits [8k+7:8k].
REQ-011 sload  out  1  one-cycle pulse that commits the assembled 32-bit correction downstream.
REQ-012 err_out  out  32  signed, unclamped phase error of the last measurement.
REQ-013 meas_valid  out  1  one-cycle pulse when err_out updates.
REQ-014 locked  out  1  tracking-in-lock status.

Function
REQ-015 in_hz shall pass through a 2-FF synchronizer and then a rising-edge detector, giving the ext_edge pulse (1 cycle).
REQ-016 A rising-edge detector on local_pps shall give the loc_edge pulse (1 cycle).
REQ-017 A 32-bit phase counter shall load 0 on loc_edge, otherwise increment, and saturate at freq.
REQ-018 States: IDLE, ARMED, CALC, WR0, WR1, WR2, WR3, LOAD, HOLD.
REQ-019 IDLE/HOLD -> ARMED on loc_edge; ext_edge is ignored in IDLE and HOLD unless it coincides with that loc_edge.
REQ-020 ARMED: on ext_edge, p = value the phase counter takes that cycle (0 if ext_edge coincides with loc_edge), then go to CALC.
REQ-021 ARMED: loc_edge without ext_edge = missed pulse; stay ARMED, clear locked, clear the lock run counter, no writes.
REQ-022 CALC: if p <= freq/2 (integer division), err = +p; else err = -(freq+1-p); latch err into err_out; pulse meas_valid.
REQ-023 CALC: if p >= freq-7, skip the writes (no margin before the downstream wrap) and go to HOLD; err_out and meas_valid still update.
REQ-024 Correction = err clamped to [-max_step, +max_step], in 32-bit two's complement.
REQ-025 WR0..WR3 shall each last one cycle: data_out = correction byte k, data_wr = 1<<k. LOAD shall last one cycle with sload=1 and data_wr=0. Then go to HOLD.
REQ-026 Latency ext_edge -> sload shall be 6 cycles (ARMED, CALC, WR0..WR3); data_wr and sload shall never be asserted together.
REQ-027 data_out shall be 0 whenever data_wr is 0.
REQ-028 Lock: run counter (3 bits, saturating) increments on each measurement with |err| <= lock_tol and clears otherwise; locked=1 when the run reaches 4; any miss clears it.
REQ-029 en low: state IDLE, data_wr=0, sload=0, locked=0; err_out holds.

Reset
REQ-030 reset shall take priority over everything: state IDLE, phase counter 0, synchronizer and edge flops 0, run counter 0.
REQ-031 During reset, data_out, data_wr, sload, err_out, meas_valid and locked shall all be 0.
REQ-032 A reset asserted during WR0..LOAD shall abort the write sequence; no further data_wr or sload in that period.

Verification (freq=99, max_step=10, lock_tol=2)
REQ-033 Reset held for 3 cycles, then en=1 with no PPS inputs -> all outputs 0 and state IDLE indefinitely.
REQ-034 Ext edge 5 cycles after the local edge -> err_out=5; bytes 05,00,00,00 on data_wr 1,2,4,8; sload 6 cycles after ext_edge.
REQ-035 p=90 -> err_out=-10, bytes F6,FF,FF,FF. p=30 -> err_out=30, clamped bytes 0A,00,00,00. p=60 -> err_out=-40, clamped bytes F6,FF,FF,FF.
REQ-036 p=95 -> meas_valid pulses and err_out=-5; no data_wr and no sload.
REQ-037 Four consecutive periods with p=1 -> locked rises after the 4th measurement. One period with no in_hz -> locked falls at that loc_edge and nothing is written.
REQ-038 reset asserted during WR1 -> no data_wr[2], data_wr[3] or sload; all outputs 0 on the next cycle.
